// File: rtl/skid_buf.sv
// skid_buf: two-entry valid/ready stage (output reg + skid reg).
// Ports: clk, rstn (sync, active-high), valid_in/data_in/ready_out
// upstream, valid_out/data_out/ready_in downstream. All outputs are flops.
module skid_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic                  r_valid_out;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_skid_valid;
  logic [DATA_WIDTH-1:0] r_skid_data;
  logic                  r_ready_out;

  logic w_in_xfer;
  logic w_out_xfer;

  assign w_in_xfer  = valid_in & r_ready_out;
  assign w_out_xfer = r_valid_out & ready_in;

  // r_ready_out mirrors !r_skid_valid but is its own flop so the
  // upstream ready never sees a combinational path.
  always_ff @(posedge clk) begin
    if (rstn) begin
      r_valid_out  <= 1'b0;
      r_data_out   <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_ready_out  <= 1'b1;
    end else if (!r_valid_out) begin
      if (w_in_xfer) begin
        r_valid_out <= 1'b1;
        r_data_out  <= data_in;
      end
    end else if (!r_skid_valid) begin
      unique case ({w_in_xfer, w_out_xfer})
        2'b11: r_data_out <= data_in;
        2'b10: begin
          r_skid_valid <= 1'b1;
          r_skid_data  <= data_in;
          r_ready_out  <= 1'b0;
        end
        2'b01: r_valid_out <= 1'b0;
        default: ;
      endcase
    end else if (w_out_xfer) begin
      r_data_out   <= r_skid_data;
      r_skid_valid <= 1'b0;
      r_ready_out  <= 1'b1;
    end
  end

  assign ready_out = r_ready_out;
  assign valid_out = r_valid_out;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_skid_buf.sv
// tb_skid_buf: queue-based reference model for skid_buf with
// directed scenarios and randomized handshakes.
module tb_skid_buf;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn;
  logic         valid_in;
  logic [W-1:0] data_in;
  logic         ready_out;
  logic         ready_in;
  logic         valid_out;
  logic [W-1:0] data_out;

  skid_buf #(.DATA_WIDTH(W)) dut (
    .clk(clk),
    .rstn(rstn),
    .valid_in(valid_in),
    .data_in(data_in),
    .ready_out(ready_out),
    .ready_in(ready_in),
    .valid_out(valid_out),
    .data_out(data_out)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: buffer contents as a FIFO of at most two words, plus the
  // last word handed downstream (what data_out shows when empty).
  logic [W-1:0] mq[$];
  logic [W-1:0] m_last;
  // Words observed leaving the DUT (for ordering checks).
  logic [W-1:0] got[$];

  task automatic chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(bit rst, bit v, logic [W-1:0] d, bit rdy);
    bit ix;
    bit ox;
    rstn     = rst;
    valid_in = v;
    data_in  = d;
    ready_in = rdy;
    #1;
    if (!rst && valid_out && rdy) got.push_back(data_out);
    @(posedge clk);
    ix = v && (mq.size() < 2);
    ox = rdy && (mq.size() > 0);
    if (rst) begin
      mq.delete();
      m_last = '0;
    end else begin
      if (ox) m_last = mq.pop_front();
      if (ix) mq.push_back(d);
    end
    #1;
    chk("valid_out", W'(valid_out), W'(mq.size() > 0));
    chk("ready_out", W'(ready_out), W'(mq.size() < 2));
    chk("data_out", data_out, (mq.size() > 0) ? mq[0] : m_last);
  endtask

  initial begin
    logic [W-1:0] pend;
    bit           pv;
    bit           acc;

    rstn = 1'b1; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
    mq.delete(); m_last = '0;

    // Reset, then idle
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_valid", W'(valid_out), 0);
    chk("rst_data", data_out, 0);
    chk("rst_ready", W'(ready_out), 1);

    // Single word passthrough
    step(0, 1, 10, 1);
    chk("single_valid", W'(valid_out), 1);
    chk("single_data", data_out, 10);
    step(0, 0, 0, 1);
    chk("single_drain", W'(valid_out), 0);

    // Fill to FULL, drain
    step(0, 1, 20, 0);
    step(0, 1, 30, 0);
    chk("full_data", data_out, 20);
    chk("full_ready", W'(ready_out), 0);
    step(0, 0, 0, 1);
    chk("skid_data", data_out, 30);
    chk("skid_ready", W'(ready_out), 1);
    step(0, 0, 0, 1);
    chk("skid_drain", W'(valid_out), 0);

    // Upstream holds 60 while buffer is full
    got.delete();
    step(0, 1, 40, 0);
    step(0, 1, 50, 0);
    step(0, 1, 60, 0);
    chk("hold_data", data_out, 40);
    chk("hold_ready", W'(ready_out), 0);
    step(0, 1, 60, 1);
    step(0, 1, 60, 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("hold_cnt", W'(got.size()), 3);
    if (got.size() == 3) begin
      chk("hold_w0", got[0], 40);
      chk("hold_w1", got[1], 50);
      chk("hold_w2", got[2], 60);
    end

    // Back-to-back stream
    got.delete();
    for (int i = 1; i <= 100; i++) begin
      step(0, 1, W'(i), 1);
      chk("stream_ready", W'(ready_out), 1);
    end
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("stream_cnt", W'(got.size()), 100);
    for (int k = 0; k < got.size(); k++)
      chk("stream_word", got[k], W'(k + 1));

    // Reset while FULL
    step(0, 1, 5, 0);
    step(0, 1, 6, 0);
    chk("pre_rst_ready", W'(ready_out), 0);
    step(1, 0, 0, 0);
    chk("mid_rst_valid", W'(valid_out), 0);
    chk("mid_rst_ready", W'(ready_out), 1);
    got.delete();
    step(0, 1, 7, 1);
    step(0, 0, 0, 1);
    chk("post_rst_cnt", W'(got.size()), 1);
    if (got.size() == 1) chk("post_rst_word", got[0], 7);

    // Randomized traffic; upstream keeps a word until accepted
    pv = 1'b0;
    pend = $urandom;
    for (int c = 0; c < 3000; c++) begin
      bit r;
      bit rdy;
      r   = ($urandom_range(0, 199) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      if (!pv) begin
        pv   = ($urandom_range(0, 3) != 0);
        pend = $urandom;
      end
      acc = pv && ready_out && !r;
      step(r, pv, pv ? pend : $urandom, rdy);
      if (acc || r) pv = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/skid_buf.md
Name: skid_buf

Overview:
- Two-entry registered valid/ready pipeline stage: an output register plus one skid register.
- Breaks the combinational ready path between a streaming producer and consumer while sustaining full throughput.
- Sits between any two streaming blocks in the accelerator datapath, such as the feature-map feed into the MAC array.
- All outputs come directly from flops.

Parameters:
- DATA_WIDTH, 32, width of data_in/data_out in bits.

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rstn  input  1  reset, synchronous, active-high (asserted = 1, sampled on rising clk).
- valid_in  input  1  upstream data valid.
- data_in  input  DATA_WIDTH  upstream data.
- ready_out  output  1  buffer can accept a word this cycle (to upstream).
- ready_in  input  1  downstream accepts data_out this cycle.
- valid_out  output  1  data_out holds a valid word (to downstream).
- data_out  output  DATA_WIDTH  downstream data.

Behaviour:
- Reset (rstn=1 at a rising edge):
  - valid_out=0, data_out=0, skid entry empty with skid data=0, ready_out=1.
  - Reset overrides all handshakes in that cycle; in-flight words are discarded.
- Handshakes:
  - Input transfer = valid_in & ready_out at a rising edge.
  - Output transfer = valid_out & ready_in at a rising edge.
- ready_out = NOT skid_valid, driven from a flop with no combinational path from ready_in or valid_in.
- State by occupancy:
  - EMPTY: valid_out=0.
  - ONE: valid_out=1, skid empty.
  - FULL: valid_out=1, skid valid, ready_out=0.
- Transitions on each rising edge:
  - EMPTY + input transfer -> ONE; data_out <= data_in.
  - ONE, input and output transfer together -> ONE; data_out <= data_in.
  - ONE, input only (downstream stalled) -> FULL; skid <= data_in; data_out unchanged.
  - ONE, output only -> EMPTY; valid_out <= 0; data_out keeps last value.
  - FULL + output transfer -> ONE; data_out <= skid; skid emptied; ready_out <= 1.
  - FULL with no output transfer -> holds.
  - In FULL, no input is accepted because ready_out=0.
- Latency: a word accepted at edge N appears on data_out with valid_out=1 after edge N if the output register is free.
- Stall rule: while valid_out=1 and ready_in=0, data_out and valid_out stay stable.
- Ordering: strict FIFO. No word is dropped, duplicated or reordered.
- valid_in while ready_out=0 is ignored; upstream must hold the word.
- data_in is don't-care when valid_in=0.
- Throughput: one word per cycle when ready_in is held at 1.
- Capacity: at most 2 words.

Test Plan:
- Reset for 2 cycles, then deassert -> valid_out=0, data_out=0, ready_out=1.
- ready_in=1; send 10 for one cycle -> next cycle valid_out=1, data_out=10; the following cycle valid_out=0.
- ready_in=0; send 20 then 30 on consecutive cycles -> data_out=20 held and ready_out=0 (FULL). Raise ready_in for one cycle -> data_out=30, ready_out=1. Next ready_in -> valid_out=0.
- ready_in=0; hold valid_in=1 while presenting 40, 50, 60 -> 40 and 50 accepted, ready_out=0 and 60 held upstream. Release ready_in=1 -> output sequence 40, 50, 60 with no loss or duplicates.
- ready_in=1; stream 1..100 back-to-back -> one word out per cycle, in order, with ready_out constantly 1.
- Fill to FULL, assert rstn for one cycle -> valid_out=0, ready_out=1; the next accepted word (7) is the first word out.
